// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: receive-side VGA timing monitor.
// Registers the packed 8-bit VGA bus, recovers hsync/vsync timing, locks onto
// a stable frame, rebuilds the (x, y, rgb) pixel stream and reports per-frame
// line/frame periods and a rotate-xor checksum of the previous frame.
// Optional build macro VGA_FRAME_MONITOR_MATCH_COUNT_EN adds a per-frame count
// of pixels equal to MATCH_RGB; without it match_count is tied to zero.
module vga_frame_monitor #(
  parameter int          H_ACTIVE        = 640,
  parameter int          H_SYNC          = 96,
  parameter int          H_BACK          = 48,
  parameter int          H_TOTAL         = 800,
  parameter int          V_ACTIVE        = 480,
  parameter int          V_SYNC          = 2,
  parameter int          V_BACK          = 33,
  parameter int          V_TOTAL         = 525,
  parameter int          SYNC_ACTIVE_LOW = 1,
  parameter int          LOCK_FRAMES     = 2,
  parameter logic [5:0]  MATCH_RGB       = 6'b11_10_00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic        err_clr,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic        locked,
  output logic [10:0] h_period,
  output logic [9:0]  v_period,
  output logic [15:0] frame_checksum,
  output logic        timing_err,
  output logic [18:0] match_count
);

  localparam logic [1:0]  ST_SEARCH  = 2'd0;
  localparam logic [1:0]  ST_ACQUIRE = 2'd1;
  localparam logic [1:0]  ST_LOCKED  = 2'd2;

  localparam logic [10:0] K_MAX   = 11'h7FF;
  localparam logic [9:0]  L_MAX   = 10'h3FF;
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);
  localparam logic        POL     = (SYNC_ACTIVE_LOW != 0);

  logic [7:0]  r_vin;
  logic        r_hs_d;
  logic        r_vs_d;
  logic [10:0] r_k;
  logic [9:0]  r_l;
  logic [1:0]  r_state;
  logic [7:0]  r_good_cnt;
  logic        r_line_err;
  logic        r_exempt;
  logic [15:0] r_cs;

  logic        w_hs;
  logic        w_vs;
  logic [5:0]  w_rgb;
  logic        w_hs_edge;
  logic        w_vs_edge;
  logic [10:0] w_k;
  logic [9:0]  w_l_inc;
  logic [9:0]  w_l;
  logic [10:0] w_h_meas;
  logic        w_h_bad;
  logic        w_sat;
  logic        w_active;
  logic        w_count;
  logic        w_frame_good;
  logic [1:0]  w_state_nxt;
  logic [7:0]  w_good_nxt;
  logic        w_terr_set;
  logic        w_enter_acq;

  // Single input register on the raw VGA bus
  always_ff @(posedge clk) begin
    if (!rst_n) r_vin <= '0;
    else        r_vin <= vga_in;
  end

  // Field decode: normalise sync polarity, reassemble {R,G,B} from split bits
  assign w_hs  = r_vin[7] ^ POL;
  assign w_vs  = r_vin[3] ^ POL;
  assign w_rgb = {r_vin[0], r_vin[4], r_vin[1], r_vin[5], r_vin[2], r_vin[6]};

  // Sync history starts "asserted" so a sync held across reset is not an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
    end else begin
      r_hs_d <= w_hs;
      r_vs_d <= w_vs;
    end
  end

  assign w_hs_edge = w_hs & ~r_hs_d;
  assign w_vs_edge = w_vs & ~r_vs_d;

  // Offset of the current sample from the last hsync edge (saturating)
  always_comb begin
    w_k = r_k;
    if (w_hs_edge)          w_k = '0;
    else if (r_k != K_MAX)  w_k = r_k + 11'd1;
  end

  // Line count including this sample's hsync edge; vsync edge restarts it
  always_comb begin
    w_l_inc = r_l;
    if (w_hs_edge && (r_l != L_MAX)) w_l_inc = r_l + 10'd1;
    w_l = w_vs_edge ? '0 : w_l_inc;
  end

  assign w_h_meas     = r_k + 11'd1;
  assign w_sat        = (w_k == K_MAX) | (w_l_inc == L_MAX);
  assign w_h_bad      = w_hs_edge & (r_state != ST_SEARCH) & ~r_exempt &
                        (w_h_meas != H_TOT);
  // An hsync edge coincident with vsync closes the last line of the frame,
  // so its measurement is folded into this frame's verdict.
  assign w_frame_good = ~(r_line_err | w_h_bad) & (w_l_inc == V_TOT);
  assign w_active     = (w_k >= H_START) && (w_k < H_END) &&
                        (w_l >= V_START) && (w_l < V_END);
  assign w_count      = w_active & (r_state != ST_SEARCH);

  // Lock FSM next-state; saturation overrides any frame evaluation
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_terr_set  = 1'b0;
    if (w_sat) begin
      w_state_nxt = ST_SEARCH;
      w_good_nxt  = '0;
      w_terr_set  = (r_state == ST_LOCKED);
    end else if (w_vs_edge) begin
      case (r_state)
        ST_SEARCH: begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = '0;
        end
        ST_ACQUIRE: begin
          if (w_frame_good) begin
            w_good_nxt = r_good_cnt + 8'd1;
            if (w_good_nxt >= LOCK_N) w_state_nxt = ST_LOCKED;
          end else begin
            w_good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_frame_good) begin
            w_state_nxt = ST_SEARCH;
            w_good_nxt  = '0;
            w_terr_set  = 1'b1;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  assign w_enter_acq = (r_state == ST_SEARCH) && (w_state_nxt == ST_ACQUIRE);

  // Timing counters and lock state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_l        <= '0;
      r_state    <= ST_SEARCH;
      r_good_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      r_k        <= w_k;
      r_l        <= w_l;
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      locked     <= (w_state_nxt == ST_LOCKED);
    end
  end

  // Line-error tracking; the first hsync edge after acquiring is not judged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line_err <= 1'b0;
      r_exempt   <= 1'b0;
    end else if (w_enter_acq) begin
      r_line_err <= 1'b0;
      r_exempt   <= 1'b1;
    end else begin
      if (w_vs_edge)    r_line_err <= 1'b0;
      else if (w_h_bad) r_line_err <= 1'b1;
      if (w_hs_edge)    r_exempt   <= 1'b0;
    end
  end

  // Line and frame period capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_period <= '0;
      v_period <= '0;
    end else begin
      if (w_hs_edge) h_period <= w_h_meas;
      if (w_vs_edge) v_period <= w_l_inc;
    end
  end

  // Frame checksum and frame_done pulse; accumulator idles at 0 in SEARCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs           <= '0;
      frame_checksum <= '0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= w_vs_edge;
      if (w_vs_edge) begin
        frame_checksum <= r_cs;
        r_cs           <= '0;
      end else if (r_state == ST_SEARCH) begin
        r_cs <= '0;
      end else if (w_count) begin
        r_cs <= {r_cs[14:0], r_cs[15]} ^ {10'b0, w_rgb};
      end
    end
  end

  // Sticky timing error; a new set beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n)          timing_err <= 1'b0;
    else if (w_terr_set) timing_err <= 1'b1;
    else if (err_clr)    timing_err <= 1'b0;
  end

  // Registered pixel stream; coordinates follow the counters every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
    end else begin
      pix_valid <= w_active & (r_state == ST_LOCKED);
      pix_x     <= 10'(w_k - H_START);
      pix_y     <= w_l - V_START;
      pix_rgb   <= w_rgb;
    end
  end

`ifdef VGA_FRAME_MONITOR_MATCH_COUNT_EN
  logic [18:0] r_mcnt;

  // Per-frame count of checksummed pixels equal to MATCH_RGB (saturating)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcnt      <= '0;
      match_count <= '0;
    end else if (w_vs_edge) begin
      match_count <= r_mcnt;
      r_mcnt      <= '0;
    end else if (w_count && (w_rgb == MATCH_RGB) && (r_mcnt != '1)) begin
      r_mcnt <= r_mcnt + 19'd1;
    end
  end
`else
  // Counter not built: output is constant zero (MATCH_RGB masked away)
  assign match_count = 19'(MATCH_RGB & 6'd0);
`endif

endmodule
